// File: rtl/axi_slv_mem_if.sv
// AXI bus bundle for axi_slv_mem.
// Carries the AR, AW, R, W and B channels. The slave modport is used by the
// memory; the master modport is for whatever drives it.
interface axi_slv_mem_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic            axi_arvalid;
  logic            axi_arready;
  logic [AW-1:0]   axi_araddr;
  logic [1:0]      axi_arburst;
  logic [3:0]      axi_arlen;

  logic            axi_awvalid;
  logic            axi_awready;
  logic [AW-1:0]   axi_awaddr;
  logic [1:0]      axi_awburst;
  logic [3:0]      axi_awlen;

  logic            axi_rvalid;
  logic            axi_rready;
  logic [DW-1:0]   axi_rdata;
  logic [1:0]      axi_rresp;
  logic            axi_rlast;

  logic            axi_wvalid;
  logic            axi_wready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;

  logic            axi_bvalid;
  logic            axi_bready;
  logic [1:0]      axi_bresp;

  modport slave (
    input  axi_arvalid, axi_araddr, axi_arburst, axi_arlen,
    input  axi_awvalid, axi_awaddr, axi_awburst, axi_awlen,
    input  axi_rready,
    input  axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    input  axi_bready,
    output axi_arready, axi_awready,
    output axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    output axi_wready,
    output axi_bvalid, axi_bresp
  );

  modport master (
    output axi_arvalid, axi_araddr, axi_arburst, axi_arlen,
    output axi_awvalid, axi_awaddr, axi_awburst, axi_awlen,
    output axi_rready,
    output axi_wvalid, axi_wdata, axi_wstrb, axi_wlast,
    output axi_bready,
    input  axi_arready, axi_awready,
    input  axi_rvalid, axi_rdata, axi_rresp, axi_rlast,
    input  axi_wready,
    input  axi_bvalid, axi_bresp
  );
endinterface

// File: rtl/axi_slv_mem.sv
// AXI slave backed by a DEPTH x DW register-file memory.
// Supports FIXED/INCR/WRAP bursts of up to 16 beats with byte strobes and a
// per-beat OKAY/SLVERR response based on address range. Read and write
// channels have independent state machines and run concurrently.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   axi  - AR/AW/R/W/B channels (slave modport of axi_slv_mem_if)
module axi_slv_mem #(
  parameter int unsigned   AW    = 32,
  parameter int unsigned   DW    = 32,
  parameter int unsigned   DEPTH = 16,
  parameter logic [AW-1:0] BASE  = '0
) (
  input  logic            clk,
  input  logic            rst,
  axi_slv_mem_if.slave    axi
);

  localparam int unsigned NB = DW / 8;
  localparam int unsigned SB = $clog2(NB);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [AW-1:0] offset_of(input logic [AW-1:0] a);
    return a - BASE;
  endfunction

  function automatic logic in_range(input logic [AW-1:0] a);
    return (offset_of(a) >> SB) < AW'(DEPTH);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    return IW'(offset_of(a) >> SB);
  endfunction

  function automatic logic burst_bad(input logic [1:0] b, input logic [3:0] l);
    return (b == 2'b11) ||
           ((b == BURST_WRAP) && !(l inside {4'd1, 4'd3, 4'd7, 4'd15}));
  endfunction

  function automatic logic [1:0] burst_eff(input logic [1:0] b, input logic [3:0] l);
    return burst_bad(b, l) ? BURST_INCR : b;
  endfunction

  // Legal WRAP lengths make (len+1) a power of two, so the window mask is
  // simply len shifted over the byte-lane bits with those bits filled.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [1:0]    b,
                                              input logic [3:0]    l);
    logic [AW-1:0] step;
    logic [AW-1:0] mask;
    step = AW'(NB);
    mask = (AW'(l) << SB) | AW'(NB - 1);
    case (b)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | ((a + step) & mask);
      default:     return a + step;
    endcase
  endfunction

  // Memory (never reset)
  logic [DW-1:0] mem_q [DEPTH];
  logic          mem_we;
  logic [IW-1:0] mem_widx;

  // Write channel state
  w_state_e      w_state_q, w_state_d;
  logic [AW-1:0] waddr_q,   waddr_d;
  logic [1:0]    wburst_q,  wburst_d;
  logic [3:0]    wlen_q,    wlen_d;
  logic [3:0]    wcnt_q,    wcnt_d;
  logic          werr_q,    werr_d;
  logic          awready_q, awready_d;
  logic          wready_q,  wready_d;
  logic          bvalid_q,  bvalid_d;
  logic [1:0]    bresp_q,   bresp_d;
  logic          wbeat_err;
  logic          wbeat_last;

  // Read channel state
  r_state_e      r_state_q, r_state_d;
  logic [AW-1:0] raddr_q,   raddr_d;
  logic [1:0]    rburst_q,  rburst_d;
  logic [3:0]    rlen_q,    rlen_d;
  logic [3:0]    rcnt_q,    rcnt_d;
  logic          rerr_q,    rerr_d;
  logic          arready_q, arready_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [1:0]    rresp_q,   rresp_d;
  logic          rlast_q,   rlast_d;
  logic          rd_load;
  logic [AW-1:0] rd_addr;
  logic          rd_err;
  logic          rd_last;

  always_comb begin
    w_state_d  = w_state_q;
    waddr_d    = waddr_q;
    wburst_d   = wburst_q;
    wlen_d     = wlen_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    mem_widx   = word_idx(waddr_q);
    wbeat_err  = werr_q;
    wbeat_last = (wcnt_q == wlen_q);

    case (w_state_q)
      W_IDLE: begin
        if (axi.axi_awvalid) begin
          waddr_d   = axi.axi_awaddr;
          wburst_d  = burst_eff(axi.axi_awburst, axi.axi_awlen);
          wlen_d    = axi.axi_awlen;
          wcnt_d    = '0;
          werr_d    = burst_bad(axi.axi_awburst, axi.axi_awlen);
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi.axi_wvalid) begin
          if (in_range(waddr_q)) begin
            mem_we = !rst;
          end else begin
            wbeat_err = 1'b1;
          end
          if (axi.axi_wlast != wbeat_last) begin
            wbeat_err = 1'b1;
          end
          werr_d = wbeat_err;
          if (wbeat_last) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wbeat_err ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            wcnt_d  = wcnt_q + 4'd1;
            waddr_d = next_addr(waddr_q, wburst_q, wlen_q);
          end
        end
      end
      W_RESP: begin
        if (axi.axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rburst_d  = rburst_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    rerr_d    = rerr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    rd_load   = 1'b0;
    rd_addr   = raddr_q;
    rd_err    = rerr_q;
    rd_last   = 1'b0;

    case (r_state_q)
      R_IDLE: begin
        if (axi.axi_arvalid) begin
          raddr_d   = axi.axi_araddr;
          rburst_d  = burst_eff(axi.axi_arburst, axi.axi_arlen);
          rlen_d    = axi.axi_arlen;
          rcnt_d    = '0;
          rerr_d    = burst_bad(axi.axi_arburst, axi.axi_arlen);
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
          rd_load   = 1'b1;
          rd_addr   = axi.axi_araddr;
          rd_err    = burst_bad(axi.axi_arburst, axi.axi_arlen);
          rd_last   = (axi.axi_arlen == 4'd0);
        end
      end
      R_DATA: begin
        if (axi.axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            raddr_d = next_addr(raddr_q, rburst_q, rlen_q);
            rcnt_d  = rcnt_q + 4'd1;
            rd_load = 1'b1;
            rd_addr = next_addr(raddr_q, rburst_q, rlen_q);
            rd_last = ((rcnt_q + 4'd1) == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // Reads sample mem_q before this edge's write lands, so a same-cycle
    // write to the same word is not visible in the loaded beat.
    if (rd_load) begin
      rdata_d = in_range(rd_addr) ? mem_q[word_idx(rd_addr)] : '0;
      rresp_d = (rd_err || !in_range(rd_addr)) ? RESP_SLVERR : RESP_OKAY;
      rlast_d = rd_last;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (axi.axi_wstrb[b]) begin
          mem_q[mem_widx][b*8 +: 8] <= axi.axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wburst_q  <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rburst_q  <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
      rerr_q    <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      waddr_q   <= waddr_d;
      wburst_q  <= wburst_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      raddr_q   <= raddr_d;
      rburst_q  <= rburst_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      rerr_q    <= rerr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign axi.axi_awready = awready_q;
  assign axi.axi_wready  = wready_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = bresp_q;
  assign axi.axi_arready = arready_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rdata   = rdata_q;
  assign axi.axi_rresp   = rresp_q;
  assign axi.axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_slv_mem.sv
// Scoreboard bench for axi_slv_mem (DW=32, DEPTH=16, BASE=0).
// Driver tasks compute expected R beats / B responses from a word-array
// model and push them into queues; a negedge monitor compares every
// presented response against the queue head.
module tb_axi_slv_mem;

  localparam int unsigned   DEPTH = 16;
  localparam logic [31:0]   BASE  = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_slv_mem_if #(.AW(32), .DW(32)) axi ();

  axi_slv_mem #(.AW(32), .DW(32), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .axi (axi)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] wd  [16];
  logic [3:0]  ws  [16];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic bad_burst(input logic [1:0] b, input logic [3:0] l);
    return (b == 2'd3) || (b == 2'd2 && !(l == 4'd1 || l == 4'd3 || l == 4'd7 || l == 4'd15));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] b,
                                            input logic [3:0] l, input int i);
    int unsigned size;
    logic [31:0] base;
    if (b == 2'd0) return a;
    if (b == 2'd2 && !bad_burst(b, l)) begin
      size = (int'(l) + 1) * 4;
      base = a - (a % size);
      return base + (((a - base) + 32'(i * 4)) % size);
    end
    return a + 32'(i * 4);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return ((a - BASE) >> 2) < DEPTH;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (axi.axi_rvalid) begin
        if (rq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL r_unexpected: rvalid=1 with no beat expected (t=%0t)", $time);
        end else begin
          chk("rdata", axi.axi_rdata, rq[0].data);
          chk("rresp", 32'(axi.axi_rresp), 32'(rq[0].resp));
          chk("rlast", 32'(axi.axi_rlast), 32'(rq[0].last));
          if (axi.axi_rready) void'(rq.pop_front());
        end
      end
      if (axi.axi_bvalid) begin
        chk("awready_during_b", 32'(axi.axi_awready), 32'd0);
        if (bq.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected: bvalid=1 with no response expected (t=%0t)", $time);
        end else begin
          chk("bresp", 32'(axi.axi_bresp), 32'(bq[0]));
          if (axi.axi_bready) void'(bq.pop_front());
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic hs_of(input int w);
    case (w)
      0:       return axi.axi_awready;
      1:       return axi.axi_wready;
      2:       return axi.axi_arready;
      3:       return axi.axi_rvalid & axi.axi_rready;
      default: return axi.axi_bvalid & axi.axi_bready;
    endcase
  endfunction

  // Advances until the handshake of channel w completes at a clock edge.
  task automatic hs(input int w, input string nm);
    int   n;
    logic h;
    n = 0;
    do begin
      @(negedge clk);
      h = hs_of(w);
      tick();
      n++;
    end while (!h && n < 64);
    if (!h) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_%s: handshake got 0 expected 1 within 64 cycles", nm);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_arready", 32'(axi.axi_arready), 32'd1);
    chk("rst_awready", 32'(axi.axi_awready), 32'd1);
    chk("rst_wready",  32'(axi.axi_wready),  32'd0);
    chk("rst_rvalid",  32'(axi.axi_rvalid),  32'd0);
    chk("rst_bvalid",  32'(axi.axi_bvalid),  32'd0);
    chk("rst_rdata",   axi.axi_rdata,        32'd0);
    chk("rst_rresp",   32'(axi.axi_rresp),   32'd0);
    chk("rst_rlast",   32'(axi.axi_rlast),   32'd0);
    chk("rst_bresp",   32'(axi.axi_bresp),   32'd0);
  endtask

  // Write burst using wd[]/ws[]. early: beat with premature wlast (-1 none).
  // abort_after: pulse reset after that beat's handshake (-1 none).
  task automatic do_write(input logic [31:0] addr, input logic [1:0] burst,
                          input logic [3:0] len, input int early,
                          input int abort_after, input int bdelay);
    logic        err;
    logic [31:0] a;
    err = bad_burst(burst, len);
    axi.axi_awaddr  = addr;
    axi.axi_awburst = burst;
    axi.axi_awlen   = len;
    axi.axi_awvalid = 1'b1;
    hs(0, "aw");
    axi.axi_awvalid = 1'b0;
    chk("wready_after_aw", 32'(axi.axi_wready), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      a = beat_addr(addr, burst, len, i);
      axi.axi_wvalid = 1'b1;
      axi.axi_wdata  = wd[i];
      axi.axi_wstrb  = ws[i];
      axi.axi_wlast  = (i == int'(len)) || (i == early);
      if (!in_rng(a)) err = 1'b1;
      if (i == early && early != int'(len)) err = 1'b1;
      hs(1, "w");
      if (in_rng(a)) begin
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mdl[widx(a)][b*8 +: 8] = wd[i][b*8 +: 8];
      end
      axi.axi_wvalid = 1'b0;
      axi.axi_wlast  = 1'b0;
      if (i == abort_after) begin
        rst = 1'b1;
        tick();
        check_reset_vals();
        rst = 1'b0;
        repeat (3) tick();
        chk("no_bvalid_after_abort", 32'(axi.axi_bvalid), 32'd0);
        return;
      end
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    chk("wready_after_last", 32'(axi.axi_wready), 32'd0);
    chk("bvalid_after_last", 32'(axi.axi_bvalid), 32'd1);
    axi.axi_bready = 1'b0;
    repeat (bdelay) tick();
    axi.axi_bready = 1'b1;
    hs(4, "b");
    axi.axi_bready = 1'b0;
    chk("awready_after_b", 32'(axi.axi_awready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [1:0] burst,
                         input logic [3:0] len, input int stall_beat,
                         input int stall_cycles);
    rbeat_t      e;
    logic [31:0] a;
    logic        bad;
    bad = bad_burst(burst, len);
    for (int i = 0; i <= int'(len); i++) begin
      a      = beat_addr(addr, burst, len, i);
      e.data = in_rng(a) ? mdl[widx(a)] : 32'd0;
      e.resp = (bad || !in_rng(a)) ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      rq.push_back(e);
    end
    axi.axi_rready  = (stall_beat != 0);
    axi.axi_araddr  = addr;
    axi.axi_arburst = burst;
    axi.axi_arlen   = len;
    axi.axi_arvalid = 1'b1;
    hs(2, "ar");
    axi.axi_arvalid = 1'b0;
    chk("rvalid_after_ar", 32'(axi.axi_rvalid), 32'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        axi.axi_rready = 1'b0;
        repeat (stall_cycles) tick();
        axi.axi_rready = 1'b1;
      end
      hs(3, "r");
    end
    axi.axi_rready = 1'b0;
    chk("rvalid_after_last", 32'(axi.axi_rvalid), 32'd0);
    chk("arready_after_last", 32'(axi.axi_arready), 32'd1);
  endtask

  task automatic fill_wd(input logic [3:0] strb);
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      ws[i] = strb;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  burst;
    logic [3:0]  len;
    logic [31:0] addr;
    int          r, early;

    axi.axi_arvalid = 1'b0; axi.axi_araddr = '0; axi.axi_arburst = '0; axi.axi_arlen = '0;
    axi.axi_awvalid = 1'b0; axi.axi_awaddr = '0; axi.axi_awburst = '0; axi.axi_awlen = '0;
    axi.axi_rready  = 1'b0; axi.axi_wvalid = 1'b0; axi.axi_wdata = '0;
    axi.axi_wstrb   = '0;   axi.axi_wlast  = 1'b0; axi.axi_bready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;

    repeat (3) tick();
    check_reset_vals();
    rst = 1'b0;
    tick();

    // Give every word a known value.
    fill_wd(4'hF);
    do_write(32'h0, 2'd1, 4'd15, -1, -1, 0);

    // Single write then read.
    wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
    do_write(32'h08, 2'd1, 4'd0, -1, -1, 0);
    do_read(32'h08, 2'd1, 4'd0, -1, 0);

    // Byte strobes.
    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(32'h10, 2'd1, 4'd0, -1, -1, 0);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
    do_write(32'h10, 2'd1, 4'd0, -1, -1, 0);
    do_read(32'h10, 2'd1, 4'd0, -1, 0);

    // Range edge.
    fill_wd(4'hF);
    do_write(32'h38, 2'd1, 4'd3, -1, -1, 0);
    do_read(32'h38, 2'd1, 4'd3, -1, 0);

    // WRAP len 3, then check words 4..7 linearly; illegal WRAP len.
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h18, 2'd2, 4'd3, -1, -1, 0);
    do_read(32'h10, 2'd1, 4'd3, -1, 0);
    do_read(32'h18, 2'd2, 4'd3, -1, 0);
    fill_wd(4'hF);
    do_write(32'h20, 2'd2, 4'd2, -1, -1, 0);

    // FIXED and reserved bursts.
    fill_wd(4'hF);
    do_write(32'h04, 2'd0, 4'd3, -1, -1, 0);
    do_read(32'h04, 2'd0, 4'd1, -1, 0);
    fill_wd(4'hF);
    do_write(32'h30, 2'd3, 4'd1, -1, -1, 0);
    do_read(32'h30, 2'd3, 4'd1, -1, 0);

    // Backpressure and early wlast.
    do_read(32'h00, 2'd1, 4'd3, 1, 3);
    fill_wd(4'hF);
    do_write(32'h24, 2'd1, 4'd0, -1, -1, 5);
    fill_wd(4'hF);
    do_write(32'h00, 2'd1, 4'd3, 1, -1, 0);
    do_read(32'h00, 2'd1, 4'd3, -1, 0);

    // Reset mid-burst after beat 1 of a len-3 write.
    fill_wd(4'hF);
    do_write(32'h20, 2'd1, 4'd3, -1, 1, 0);
    do_read(32'h20, 2'd1, 4'd3, -1, 0);

    // Randomized bursts.
    for (int it = 0; it < 40; it++) begin
      burst = 2'($urandom_range(0, 3));
      len   = 4'($urandom_range(0, 15));
      r     = $urandom_range(0, 7);
      if (r == 0) addr = $urandom;
      else addr = (32'($urandom_range(0, 72)) & 32'hFFFF_FFFC) | ((r == 1) ? 32'($urandom_range(0, 3)) : 32'd0);
      for (int i = 0; i < 16; i++) begin
        wd[i] = $urandom;
        ws[i] = 4'($urandom_range(0, 15));
      end
      early = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1;
      do_write(addr, burst, len, early, -1, $urandom_range(0, 3));
      do_read(addr, burst, len, ($urandom_range(0, 2) == 0) ? $urandom_range(0, int'(len)) : -1,
              $urandom_range(1, 3));
    end

    repeat (2) tick();
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_slv_mem.md
# axi_slv_mem

Parametrised AXI slave with an internal word-addressed register-file memory. It is the DMA subsystem's standalone target, replacing the tie-off slave stub for engine bring-up and loopback tests. It accepts FIXED, INCR and WRAP bursts of up to 16 beats with byte strobes. Each beat carries its own OKAY/SLVERR status based on address range. Independent read and write state machines give one beat per cycle in each direction.

## Interface
- AW, 32, address width in bits.
- DW, 32, data width in bits; power of two, at least 8.
- DEPTH, 16, number of DW-bit words; power of two.
- BASE, 0, byte base address of word 0; aligned to DEPTH*DW/8.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- axi_arvalid / axi_arready  in / out  1  read address handshake.
- axi_araddr  in  AW  read burst start byte address.
- axi_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- axi_arlen  in  4  beats minus one.
- axi_awvalid / axi_awready  in / out  1  write address handshake.
- axi_awaddr, axi_awburst, axi_awlen  in  AW, 2, 4  write burst; same encoding as read.
- axi_rvalid / axi_rready  out / in  1  read data handshake.
- axi_rdata  out  DW  read beat data.
- axi_rresp  out  2  per-beat response: 00 OKAY, 10 SLVERR.
- axi_rlast  out  1  final beat of the burst.
- axi_wvalid / axi_wready  in / out  1  write data handshake.
- axi_wdata  in  DW  write beat data.
- axi_wstrb  in  DW/8  byte enables.
- axi_wlast  in  1  master's last-beat flag.
- axi_bvalid / axi_bready  out / in  1  write response handshake.
- axi_bresp  out  2  burst response: 00 OKAY, 10 SLVERR.

## Operation
- Addressing:
  - Offset = addr - BASE, modulo 2^AW.
  - Word index = offset >> log2(DW/8).
  - A beat is in range when index < DEPTH.
  - Low byte-offset bits are ignored.
  - Transfer size is always full DW.
- Beat address update, in bytes:
  - FIXED: unchanged.
  - INCR: +DW/8, AW-bit wrap.
  - WRAP: +DW/8 within an aligned window of (len+1)*DW/8 bytes. WRAP is legal only for len 1, 3, 7 or 15.
- Error bursts:
  - Reserved burst type, or WRAP with an illegal len, is executed as INCR.
  - Every beat of such a burst responds SLVERR.
- Write FSM:
  - States: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
  - An AW handshake in W_IDLE captures address, burst type and len, clears the beat counter and the error flag, then goes to W_DATA.
  - Each W handshake writes the strobed bytes of the addressed word. Out-of-range beats are discarded and set the error flag.
  - The beat counter alone ends the burst: after handshake number len+1, go to W_RESP.
  - An axi_wlast mismatch on any beat (asserted early, or absent on the final beat) sets the error flag.
  - bresp = 10 if the error flag is set, else 00.
  - A B handshake returns the FSM to W_IDLE.
- Read FSM:
  - States: R_IDLE (arready=1), R_DATA (rvalid=1).
  - An AR handshake captures the burst and loads beat 0 into the output registers (rdata, rresp, rlast).
  - Each R handshake on a non-last beat loads the next beat. After the last handshake, go to R_IDLE.
  - An out-of-range beat returns rdata=0 with rresp=10.
  - rlast=1 exactly on beat len.
- Read and write run fully concurrently.
- Memory contents are never reset.
- Same-cycle collision: a beat loaded into the read registers in the same cycle as a write to that word sees the old contents.

## Timing
- Reset values:
  - arready=1, awready=1.
  - wready=0, rvalid=0, bvalid=0.
  - rdata=0, rresp=00, rlast=0, bresp=00.
- Reset mid-burst: both FSMs go to IDLE at the next edge. Beats already written persist. No B or R response is issued for the aborted burst.
- Write latency:
  - AW handshake at edge T gives wready=1 from T+1.
  - Final W handshake at edge T' gives wready=0 and bvalid=1 from T'+1.
  - bvalid holds until the edge where bready=1; awready=1 from the next cycle.
- Read latency:
  - AR handshake at edge T gives rvalid=1 and beat 0 from T+1.
  - Back-to-back beats run one per cycle while rready=1.
  - After the last handshake, rvalid=0 and arready=1 in the next cycle.
- Stability under backpressure: rdata, rresp and rlast stay stable while rvalid=1 and rready=0; bresp stays stable while bvalid=1.
- No new AW is accepted until B completes. No new AR is accepted until the last R beat completes.

## Test plan
All scenarios use DW=32, DEPTH=16, BASE=0.
- Single write then read: AW 0x08, len 0, INCR; W 0xDEADBEEF, strb 0xF, wlast=1 -> bresp 00. AR 0x08, len 0 -> one beat 0xDEADBEEF, rresp 00, rlast=1.
- Byte strobes: write 0x11223344 to 0x10, then 0xAABBCCDD with strb 0x5 -> readback 0x11BB33DD.
- Range edge: INCR len 3 at 0x38 -> words 14 and 15 are written, bresp 10. Read of the same burst -> beats 0-1 return data with rresp 00; beats 2-3 return 0 with rresp 10.
- WRAP: len 3 at 0x18, writing data 1, 2, 3, 4 -> words 6, 7, 4, 5 hold 1, 2, 3, 4. WRAP with len 2 -> bresp 10.
- Backpressure: rready low for 3 cycles on beat 1 -> rvalid and rdata hold. bready low for 5 cycles -> bvalid holds and awready stays 0. wlast asserted on beat 1 of a len-3 burst -> all 4 beats accepted, bresp 10.
- Reset mid-burst: rst for 1 cycle after beat 1 of a len-3 write -> all outputs return to reset values. Beats 0-1 are retained in memory, beats 2-3 are not written, and no bvalid is issued.
